// File: rtl/obd_uart_responder_if.sv
// Pin-level bundle of the OBD responder: UART lines, vehicle data inputs and status outputs.
// The responder uses the slave view; a tester or vehicle model drives the master view.
interface obd_uart_responder_if;
  logic        uart_rx;
  logic        uart_tx;
  logic [7:0]  speed;
  logic [13:0] rpm;
  logic [7:0]  fuel;
  logic [7:0]  temp;
  logic [31:0] odometer_raw;
  logic [2:0]  gear_num;
  logic        ess_trigger;
  logic        busy;
  logic        frame_err;
  logic        overrun;
  logic [7:0]  req_count;

  modport slave (
    input  uart_rx, speed, rpm, fuel, temp, odometer_raw, gear_num, ess_trigger,
    output uart_tx, busy, frame_err, overrun, req_count
  );

  modport master (
    output uart_rx, speed, rpm, fuel, temp, odometer_raw, gear_num, ess_trigger,
    input  uart_tx, busy, frame_err, overrun, req_count
  );
endinterface

// File: rtl/obd_uart_responder.sv
// OBD-style UART responder: receives 1-byte PID requests and replies with a framed,
// XOR-checksummed snapshot of the vehicle data (HDR, PID, LEN, DATA[LEN], CHK).
module obd_uart_responder #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HDR_ACK      = 8'h7E,
  parameter logic [7:0]  HDR_NAK      = 8'h7F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  obd_uart_responder_if.slave   bus
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND}           tx_state_t;

  rx_state_t     rx_state, rx_state_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick, rx_accept, rx_bad_stop;

  logic          slot_full;
  logic [7:0]    slot_data;
  logic [7:0]    req_count;
  logic          frame_err, overrun;

  tx_state_t     tx_state, tx_state_next;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [2:0]    tx_byte, tx_last;
  logic          tx_line, busy;
  logic          tx_tick, tx_pop, tx_done;
  logic [7:0]    frame [8];
  logic [7:0]    build [8];
  logic [2:0]    build_last;

  // ---------------------------------------------------------------- RX
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rx_state_next = rx_state;
    rx_accept     = 1'b0;
    rx_bad_stop   = 1'b0;
    rx_tick       = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
      RX_START: if (rx_tick) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_next = RX_STOP;
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_next = RX_IDLE;
          rx_accept     = rx_sync;
          rx_bad_stop   = !rx_sync;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_next;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_START) begin
        rx_bit <= '0;
      end else if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------- pending slot
  // A push coinciding with the LOAD pop refills the slot instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= 1'b0;
      slot_data <= '0;
      req_count <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= rx_bad_stop;
      overrun   <= 1'b0;
      if (rx_accept) begin
        if (slot_full && !tx_pop) begin
          overrun <= 1'b1;
        end else begin
          slot_data <= rx_shift;
          slot_full <= 1'b1;
          req_count <= req_count + 8'd1;
        end
      end else if (tx_pop) begin
        slot_full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- frame builder
  always_comb begin
    logic [7:0]  hdr, chk;
    logic [2:0]  len;
    logic [31:0] payload, data_be;
    hdr     = HDR_ACK;
    len     = 3'd0;
    payload = '0;
    case (slot_data)
      8'h0D:   begin len = 3'd1; payload = {24'b0, bus.speed}; end
      8'h0C:   begin len = 3'd2; payload = {16'b0, 2'b00, bus.rpm}; end
      8'h2F:   begin len = 3'd1; payload = {24'b0, bus.fuel}; end
      8'h05:   begin len = 3'd1; payload = {24'b0, bus.temp}; end
      8'hA6:   begin len = 3'd4; payload = bus.odometer_raw; end
      8'hA4:   begin len = 3'd1; payload = {24'b0, 4'b0, bus.ess_trigger, bus.gear_num}; end
      default: hdr = HDR_NAK;
    endcase
    // Left-align the payload so byte i of the big-endian data is always bits [31-8i -: 8].
    data_be = payload << {3'd4 - len, 3'b000};
    build   = '{default: 8'h00};
    build[0] = hdr;
    build[1] = slot_data;
    build[2] = {5'b0, len};
    chk = slot_data ^ {5'b0, len};
    for (int i = 0; i < 4; i++) begin
      chk = chk ^ data_be[31 - 8*i -: 8];
      if (i < int'(len)) build[3 + i] = data_be[31 - 8*i -: 8];
    end
    build_last        = 3'd3 + len;
    build[build_last] = chk;
  end

  // ---------------------------------------------------------------- TX
  assign tx_pop  = (tx_state == TX_LOAD);
  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_done = tx_tick && (tx_bit == 4'd9) && (tx_byte == tx_last);

  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE: if (slot_full) tx_state_next = TX_LOAD;
      TX_LOAD: tx_state_next = TX_SEND;
      TX_SEND: if (tx_done) tx_state_next = TX_IDLE;
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // NOTE: the frame buffer has no reset; LOAD always writes it before SEND reads it.
  always_ff @(posedge clk) begin
    if (tx_pop) frame <= build;
  end

  // tx_bit: 0 = start, 1..8 = data LSB first, 9 = stop; uart_tx is registered to stay glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      busy     <= 1'b0;
      tx_line  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_last  <= '0;
    end else begin
      tx_state <= tx_state_next;
      busy     <= (tx_state_next != TX_IDLE);
      case (tx_state)
        TX_LOAD: begin
          tx_cnt  <= '0;
          tx_bit  <= '0;
          tx_byte <= '0;
          tx_last <= build_last;
          tx_line <= 1'b0;
        end
        TX_SEND: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              if (tx_done) begin
                tx_line <= 1'b1;
              end else begin
                tx_byte <= tx_byte + 3'd1;
                tx_bit  <= '0;
                tx_line <= 1'b0;
              end
            end else begin
              tx_bit  <= tx_bit + 4'd1;
              tx_line <= (tx_bit == 4'd8) ? 1'b1 : frame[tx_byte][tx_bit[2:0]];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_line <= 1'b1;
      endcase
    end
  end

  assign bus.uart_tx   = tx_line;
  assign bus.busy      = busy;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;
  assign bus.req_count = req_count;

endmodule

// File: tb/tb_obd_uart_responder.sv
// Bench for obd_uart_responder: a UART driver sends PID requests, expected response bytes are
// queued per request, and a TX decoder pops and compares each byte as it comes off uart_tx.
module tb_obd_uart_responder;
  localparam int CPB = 8;

  typedef logic [7:0] frame_t [8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obd_uart_responder_if bus();

  obd_uart_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         tests_run = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  int         ferr_seen = 0;
  int         ovr_seen = 0;
  bit         mon_active = 1'b0;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
    if (bus.overrun === 1'b1)   ovr_seen  <= ovr_seen + 1;
  end

  task automatic mon_wait(input int n, inout bit aborted);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) aborted = 1'b1;
    end
  endtask

  // TX decoder: samples each bit near its middle, aborts silently if reset hits mid-byte.
  initial begin : tx_monitor
    logic [7:0] b;
    logic [7:0] e;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.uart_tx === 1'b0) begin
        mon_active = 1'b1;
        aborted    = 1'b0;
        b          = '0;
        mon_wait(3, aborted);
        if (!aborted) begin
          tests_run++;
          if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_at_start: busy=%b, required 1", bus.busy);
          end
        end
        for (int i = 0; i < 8; i++) begin
          if (!aborted) begin
            mon_wait(CPB, aborted);
            b[i] = bus.uart_tx;
          end
        end
        if (!aborted) mon_wait(CPB, aborted);
        if (!aborted) begin
          tests_run++;
          if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL stop_bit: uart_tx=%b busy=%b, required 1/1", bus.uart_tx, bus.busy);
          end
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL tx_byte: got %h, required no byte", b);
          end else begin
            e = exp_q.pop_front();
            if (b !== e) begin
              fails++;
              $display("FAIL tx_byte: got %h, required %h", b, e);
            end
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic expect_frame(input frame_t f, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(f[i]);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.uart_rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.busy === 1'b1 || mon_active) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (cyc >= 3000) begin
      fails++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d cycles, required 0", name,
               exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  task automatic wait_tx_start(input string name);
    int cyc = 0;
    while (bus.uart_tx !== 1'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (cyc >= 100) begin
      fails++;
      $display("FAIL %s_tx_start: no start bit within %0d cycles", name, cyc);
    end
  endtask

  task automatic check_count(input string name, input logic [7:0] required);
    tests_run++;
    if (bus.req_count !== required) begin
      fails++;
      $display("FAIL %s_req_count: got %0d, required %0d", name, bus.req_count, required);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.uart_tx, bus.busy, bus.frame_err, bus.overrun} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_outputs: tx/busy/ferr/ovr=%b, required 1000",
               {bus.uart_tx, bus.busy, bus.frame_err, bus.overrun});
    end
    check_count("reset", 8'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_speed();
    bus.speed = 8'd100;
    expect_frame('{8'h7E, 8'h0D, 8'h01, 8'h64, 8'h68, 8'h00, 8'h00, 8'h00}, 5);
    uart_send(8'h0D, 1'b1);
    wait_drain("speed");
    check_count("speed", 8'd1);
  endtask

  task automatic test_rpm_coherent();
    bus.rpm = 14'd3000;
    expect_frame('{8'h7E, 8'h0C, 8'h02, 8'h0B, 8'hB8, 8'hBD, 8'h00, 8'h00}, 6);
    uart_send(8'h0C, 1'b1);
    wait_tx_start("rpm");
    bus.rpm = 14'd5000;
    wait_drain("rpm");
    check_count("rpm", 8'd2);
  endtask

  task automatic test_odometer();
    bus.odometer_raw = 32'h0001_2345;
    expect_frame('{8'h7E, 8'hA6, 8'h04, 8'h00, 8'h01, 8'h23, 8'h45, 8'hC5}, 8);
    uart_send(8'hA6, 1'b1);
    wait_drain("odo");
    check_count("odo", 8'd3);
  endtask

  task automatic test_nak_and_frame_err();
    int  ferr0;
    bit  saw_busy = 1'b0;
    expect_frame('{8'h7F, 8'h55, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    uart_send(8'h55, 1'b1);
    wait_drain("nak");
    check_count("nak", 8'd4);
    ferr0 = ferr_seen;
    uart_send(8'h0D, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) saw_busy = 1'b1;
    end
    tests_run++;
    if (ferr_seen != ferr0 + 1) begin
      fails++;
      $display("FAIL frame_err_pulse: saw %0d pulses, required 1", ferr_seen - ferr0);
    end
    tests_run++;
    if (saw_busy) begin
      fails++;
      $display("FAIL frame_err_no_tx: busy=1 seen, required 0");
    end
    check_count("frame_err", 8'd4);
  endtask

  task automatic test_back_to_back();
    int ovr0;
    int cyc;
    int low;
    bus.speed = 8'h21;
    bus.fuel  = 8'h40;
    bus.temp  = 8'h5A;
    expect_frame('{8'h7E, 8'h0D, 8'h01, 8'h21, 8'h2D, 8'h00, 8'h00, 8'h00}, 5);
    expect_frame('{8'h7E, 8'h2F, 8'h01, 8'h40, 8'h6E, 8'h00, 8'h00, 8'h00}, 5);
    ovr0 = ovr_seen;
    uart_send(8'h0D, 1'b1);
    uart_send(8'h2F, 1'b1);
    uart_send(8'h05, 1'b1);
    repeat (2) @(negedge clk);
    tests_run++;
    if (ovr_seen != ovr0 + 1) begin
      fails++;
      $display("FAIL overrun_pulse: saw %0d pulses, required 1", ovr_seen - ovr0);
    end
    check_count("b2b", 8'd6);
    // busy drops for exactly the one IDLE cycle before the pending request enters LOAD.
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    low = 0;
    while (bus.busy !== 1'b1 && low < 50) begin
      @(negedge clk);
      low++;
    end
    tests_run++;
    if (cyc >= 1000 || low != 1) begin
      fails++;
      $display("FAIL b2b_gap: busy low for %0d cycles (wait %0d), required 1", low, cyc);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_send();
    bus.speed = 8'h10;
    expect_frame('{8'h7E, 8'h0D, 8'h01, 8'h10, 8'h1C, 8'h00, 8'h00, 8'h00}, 5);
    uart_send(8'h0D, 1'b1);
    wait_tx_start("rst_mid");
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_send: uart_tx=%b busy=%b, required 1/0", bus.uart_tx, bus.busy);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_count("rst_mid", 8'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.gear_num    = 3'd3;
    bus.ess_trigger = 1'b1;
    expect_frame('{8'h7E, 8'hA4, 8'h01, 8'h0B, 8'hAE, 8'h00, 8'h00, 8'h00}, 5);
    uart_send(8'hA4, 1'b1);
    wait_drain("gear");
    check_count("gear", 8'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.uart_rx      = 1'b1;
    bus.speed        = '0;
    bus.rpm          = '0;
    bus.fuel         = '0;
    bus.temp         = '0;
    bus.odometer_raw = '0;
    bus.gear_num     = 3'd1;
    bus.ess_trigger  = 1'b0;
    test_reset();
    test_speed();
    test_rpm_coherent();
    test_odometer();
    test_nak_and_frame_err();
    test_back_to_back();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
